conv2d_layer_sequencer: RTL

//  Host-side writer for the conv2d control memory (16 x 32b, true dual-port; this block owns port A).

---
 rtl/conv2d_layer_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/conv2d_layer_sequencer.sv
// conv2d_layer_sequencer
// Host-side writer for port A of the conv2d control memory. Takes one layer
// descriptor per handshake, writes PARAM1, PARAM2 and the nine kernel taps,
// fires CTRL.start, then polls CTRL until the accelerator posts done (or the
// poll phase runs out of time) and reports the outcome with a one-cycle pulse.
module conv2d_layer_sequencer #(
    parameter int          DATA_WIDTH = 16,
    parameter int          POLL_GAP   = 8,
    parameter int unsigned TIMEOUT    = 24'hFFFFFF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [7:0]                i_width,
    input  logic [7:0]                i_height,
    input  logic [1:0]                i_kernel_sz,
    input  logic                      i_pad,
    input  logic [1:0]                i_stride,
    input  logic [9:0]                i_ci,
    input  logic [9:0]                i_co,
    input  logic                      i_conv,
    input  logic                      i_bn,
    input  logic                      i_maxpool,
    input  logic [3:0]                i_layer,
    input  logic [9*DATA_WIDTH-1:0]   i_kernel,
    output logic [3:0]                o_ctrl_addr,
    output logic                      o_ctrl_we,
    output logic [31:0]               o_ctrl_wdata,
    input  logic [31:0]               i_ctrl_rdata,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_timeout
);

    typedef enum logic [3:0] {
        IDLE, WR_P1, WR_P2, WR_K, WR_CTRL, POLL_WAIT, POLL_RD, POLL_CHK, CLR, ABORT
    } state_t;

    localparam int                GAP_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(POLL_GAP - 1);
    localparam logic [23:0]       TIMEOUT_LIM = 24'(TIMEOUT);

    state_t                    state, state_n;
    logic [3:0]                tap_idx, tap_n;
    logic [GAP_W-1:0]          gap_cnt, gap_n;
    logic [23:0]               to_cnt;

    logic [31:0]               p1_q, p2_q;
    logic [6:0]                op_q;
    logic [9*DATA_WIDTH-1:0]   kernel_q;

    logic                      accept;
    logic [31:0]               p1_in, p2_in, p1_sel, p2_sel;
    logic [6:0]                op_in, op_sel;
    logic [9*DATA_WIDTH-1:0]   kernel_sel;

    logic [3:0]                addr_n;
    logic                      we_n, done_n, to_n;
    logic [31:0]               wdata_n;

    // Only the done/start flags of CTRL matter for polling.
    logic                      unused_rdata;
    assign unused_rdata = ^i_ctrl_rdata[31:2];

    // The register words are assembled straight from the descriptor; while a
    // descriptor is being accepted the live inputs stand in for the not-yet
    // loaded registers so the first write can be issued on the next cycle.
    assign accept     = (state == IDLE) && i_cmd_valid;
    assign p1_in      = {11'b0, i_stride, i_pad, i_kernel_sz, i_height, i_width};
    assign p2_in      = {12'b0, i_co, i_ci};
    assign op_in      = {i_layer, i_maxpool, i_bn, i_conv};
    assign p1_sel     = accept ? p1_in    : p1_q;
    assign p2_sel     = accept ? p2_in    : p2_q;
    assign op_sel     = accept ? op_in    : op_q;
    assign kernel_sel = accept ? i_kernel : kernel_q;

    // State, tap index and poll-gap counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            tap_idx <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            tap_idx <= tap_n;
            gap_cnt <= gap_n;
        end
    end

    // Next-state logic: linear write sequence, then a wait/read/check poll loop.
    always_comb begin
        state_n = state;
        tap_n   = '0;
        gap_n   = '0;
        case (state)
            IDLE:      if (i_cmd_valid) state_n = WR_P1;
            WR_P1:     state_n = WR_P2;
            WR_P2:     state_n = WR_K;
            WR_K: begin
                if (tap_idx == 4'd8) state_n = WR_CTRL;
                else                 tap_n   = tap_idx + 4'd1;
            end
            WR_CTRL:   state_n = POLL_WAIT;
            POLL_WAIT: begin
                if (gap_cnt == GAP_LAST) state_n = POLL_RD;
                else                     gap_n   = gap_cnt + 1'b1;
            end
            POLL_RD:   state_n = POLL_CHK;
            POLL_CHK: begin
                if (i_ctrl_rdata[1] && !i_ctrl_rdata[0]) state_n = CLR;
                else if (to_cnt >= TIMEOUT_LIM)          state_n = ABORT;
                else                                     state_n = POLL_WAIT;
            end
            CLR:       state_n = IDLE;
            ABORT:     state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Output values for the state being entered, so the registered outputs line up with it.
    always_comb begin
        addr_n  = '0;
        we_n    = 1'b0;
        wdata_n = '0;
        done_n  = 1'b0;
        to_n    = 1'b0;
        case (state_n)
            WR_P1: begin
                addr_n  = 4'd2;
                we_n    = 1'b1;
                wdata_n = p1_sel;
            end
            WR_P2: begin
                addr_n  = 4'd3;
                we_n    = 1'b1;
                wdata_n = p2_sel;
            end
            WR_K: begin
                addr_n  = 4'd4 + tap_n;
                we_n    = 1'b1;
                wdata_n = 32'(kernel_sel[int'(tap_n)*DATA_WIDTH +: DATA_WIDTH]);
            end
            WR_CTRL: begin
                we_n    = 1'b1;
                wdata_n = {23'b0, op_sel, 2'b01};
            end
            CLR: begin
                we_n    = 1'b1;
                wdata_n = {23'b0, op_sel[6:3], 5'b0};
                done_n  = 1'b1;
            end
            ABORT: begin
                we_n    = 1'b1;
                to_n    = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs; ready and busy simply mirror whether the next state is IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ctrl_addr  <= '0;
            o_ctrl_we    <= 1'b0;
            o_ctrl_wdata <= '0;
            o_done       <= 1'b0;
            o_timeout    <= 1'b0;
            o_busy       <= 1'b0;
            o_cmd_ready  <= 1'b1;
        end else begin
            o_ctrl_addr  <= addr_n;
            o_ctrl_we    <= we_n;
            o_ctrl_wdata <= wdata_n;
            o_done       <= done_n;
            o_timeout    <= to_n;
            o_busy       <= (state_n != IDLE);
            o_cmd_ready  <= (state_n == IDLE);
        end
    end

    // Descriptor capture on accept, and the saturating poll-phase timeout counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1_q     <= '0;
            p2_q     <= '0;
            op_q     <= '0;
            kernel_q <= '0;
            to_cnt   <= '0;
        end else begin
            if (accept) begin
                p1_q     <= p1_in;
                p2_q     <= p2_in;
                op_q     <= op_in;
                kernel_q <= i_kernel;
            end
            if (state == WR_CTRL) begin
                to_cnt <= '0;
            end else if ((state == POLL_WAIT || state == POLL_RD || state == POLL_CHK)
                         && to_cnt != '1) begin
                to_cnt <= to_cnt + 24'd1;
            end
        end
    end

endmodule
